// File: rtl/reg_file_sb.sv
// Scoreboarded register file: 31 entries (x1..x31) with data, write tag and dirty bit, 3 combinational read ports.
// Optional macro REG_FILE_SB_DATA_RST_EN makes reset also clear the data fields.

module reg_file_sb_entry #(
  parameter int TAG_WIDTH = 2,
  parameter int IDX       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alloc_en,
  input  logic [4:0]           alloc_addr,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [TAG_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_wdata,
  input  logic                 flush,
  output logic [31:0]          data,
  output logic [TAG_WIDTH-1:0] tag,
  output logic                 dirty,
  output logic                 dirty_nxt
);
  localparam logic [4:0] ADDR = 5'(IDX);

  logic                 alloc_hit, wb_hit;
  logic [TAG_WIDTH-1:0] tag_d;
  logic [31:0]          data_d;

  assign alloc_hit = alloc_en && (alloc_addr == ADDR);
  assign wb_hit    = wb_en && (wb_addr == ADDR);

  // Allocation beats a same-cycle writeback, flush beats both; tag still advances under flush.
  always_comb begin
    tag_d     = tag;
    data_d    = data;
    dirty_nxt = dirty;
    if (alloc_hit) tag_d = tag + TAG_WIDTH'(1);
    if (wb_hit) data_d = wb_wdata;
    if (flush)                              dirty_nxt = 1'b0;
    else if (alloc_hit)                     dirty_nxt = 1'b1;
    else if (wb_hit && (wb_tag == tag))     dirty_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag   <= '0;
      dirty <= 1'b0;
`ifdef REG_FILE_SB_DATA_RST_EN
      data  <= '0;
`endif
    end else begin
      tag   <= tag_d;
      dirty <= dirty_nxt;
      data  <= data_d;
    end
  end
endmodule

module reg_file_sb_rd_port #(
  parameter int TAG_WIDTH = 2
) (
  input  logic                           en,
  input  logic [4:0]                     addr,
  input  logic [31:0][31:0]              data_all,
  input  logic [31:0][TAG_WIDTH-1:0]     tag_all,
  input  logic [31:0]                    dirty_all,
  output logic [31:0]                    data,
  output logic [TAG_WIDTH-1:0]           tag,
  output logic                           dirty
);
  logic hit;
  assign hit   = en && (addr != 5'd0);
  assign data  = hit ? data_all[addr]  : '0;
  assign tag   = hit ? tag_all[addr]   : '0;
  assign dirty = hit ? dirty_all[addr] : 1'b0;
endmodule

module reg_file_sb #(
  parameter int TAG_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_rf1_en,
  input  logic [4:0]           rd_rf1_addr,
  output logic [31:0]          rd_rf1_data,
  output logic [TAG_WIDTH-1:0] rd_rf1_tag,
  output logic                 rd_rf1_dirty,
  input  logic                 rd_rf2_en,
  input  logic [4:0]           rd_rf2_addr,
  output logic [31:0]          rd_rf2_data,
  output logic [TAG_WIDTH-1:0] rd_rf2_tag,
  output logic                 rd_rf2_dirty,
  input  logic                 rd_rf3_en,
  input  logic [4:0]           rd_rf3_addr,
  output logic [31:0]          rd_rf3_data,
  output logic [TAG_WIDTH-1:0] rd_rf3_tag,
  output logic                 rd_rf3_dirty,
  input  logic                 alloc_en,
  input  logic [4:0]           alloc_addr,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [TAG_WIDTH-1:0] wb_tag,
  input  logic [31:0]          wb_wdata,
  input  logic                 flush,
  output logic [5:0]           dirty_cnt
);
  localparam int NUM_RD = 3;

  // Slot 0 is hard-wired zero so x0 reads need no special indexing.
  logic [31:0][31:0]          data_all;
  logic [31:0][TAG_WIDTH-1:0] tag_all;
  logic [31:0]                dirty_all, dirty_nxt;
  logic [5:0]                 cnt_d;

  assign data_all[0]  = '0;
  assign tag_all[0]   = '0;
  assign dirty_all[0] = 1'b0;
  assign dirty_nxt[0] = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_ent
    reg_file_sb_entry #(.TAG_WIDTH(TAG_WIDTH), .IDX(i)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc_en  (alloc_en),
      .alloc_addr(alloc_addr),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_tag    (wb_tag),
      .wb_wdata  (wb_wdata),
      .flush     (flush),
      .data      (data_all[i]),
      .tag       (tag_all[i]),
      .dirty     (dirty_all[i]),
      .dirty_nxt (dirty_nxt[i])
    );
  end

  assign alloc_tag = (alloc_addr == 5'd0) ? '0 : tag_all[alloc_addr] + TAG_WIDTH'(1);

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < 32; i++) cnt_d = cnt_d + 6'(dirty_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dirty_cnt <= '0;
    else        dirty_cnt <= cnt_d;
  end

  logic [NUM_RD-1:0]                rd_en;
  logic [NUM_RD-1:0][4:0]           rd_addr;
  logic [NUM_RD-1:0][31:0]          rd_data;
  logic [NUM_RD-1:0][TAG_WIDTH-1:0] rd_tag;
  logic [NUM_RD-1:0]                rd_dirty;

  assign rd_en   = {rd_rf3_en, rd_rf2_en, rd_rf1_en};
  assign rd_addr = {rd_rf3_addr, rd_rf2_addr, rd_rf1_addr};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    reg_file_sb_rd_port #(.TAG_WIDTH(TAG_WIDTH)) u_rd (
      .en       (rd_en[p]),
      .addr     (rd_addr[p]),
      .data_all (data_all),
      .tag_all  (tag_all),
      .dirty_all(dirty_all),
      .data     (rd_data[p]),
      .tag      (rd_tag[p]),
      .dirty    (rd_dirty[p])
    );
  end

  assign rd_rf1_data  = rd_data[0];
  assign rd_rf1_tag   = rd_tag[0];
  assign rd_rf1_dirty = rd_dirty[0];
  assign rd_rf2_data  = rd_data[1];
  assign rd_rf2_tag   = rd_tag[1];
  assign rd_rf2_dirty = rd_dirty[1];
  assign rd_rf3_data  = rd_data[2];
  assign rd_rf3_tag   = rd_tag[2];
  assign rd_rf3_dirty = rd_dirty[2];
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed vector bench for reg_file_sb (TAG_WIDTH=2).
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_rf1_en, rd_rf2_en, rd_rf3_en;
  logic [4:0]  rd_rf1_addr, rd_rf2_addr, rd_rf3_addr;
  logic [31:0] rd_rf1_data, rd_rf2_data, rd_rf3_data;
  logic [1:0]  rd_rf1_tag, rd_rf2_tag, rd_rf3_tag;
  logic        rd_rf1_dirty, rd_rf2_dirty, rd_rf3_dirty;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic [1:0]  alloc_tag;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [1:0]  wb_tag;
  logic [31:0] wb_wdata;
  logic        flush;
  logic [5:0]  dirty_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.TAG_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_rf1_en(rd_rf1_en), .rd_rf1_addr(rd_rf1_addr), .rd_rf1_data(rd_rf1_data),
    .rd_rf1_tag(rd_rf1_tag), .rd_rf1_dirty(rd_rf1_dirty),
    .rd_rf2_en(rd_rf2_en), .rd_rf2_addr(rd_rf2_addr), .rd_rf2_data(rd_rf2_data),
    .rd_rf2_tag(rd_rf2_tag), .rd_rf2_dirty(rd_rf2_dirty),
    .rd_rf3_en(rd_rf3_en), .rd_rf3_addr(rd_rf3_addr), .rd_rf3_data(rd_rf3_data),
    .rd_rf3_tag(rd_rf3_tag), .rd_rf3_dirty(rd_rf3_dirty),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_tag(alloc_tag),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_wdata(wb_wdata),
    .flush(flush), .dirty_cnt(dirty_cnt)
  );

  typedef struct {
    logic        a_en;
    logic [4:0]  a_addr;
    logic        w_en;
    logic [4:0]  w_addr;
    logic [1:0]  w_tag;
    logic [31:0] w_data;
    logic        fl;
    logic        r_en;
    logic [4:0]  r_addr;
    logic [1:0]  e_atag;
    logic        chk_d;
    logic [31:0] e_data;
    logic [1:0]  e_tag;
    logic        e_dirty;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic a_en, logic [4:0] a_addr, logic w_en, logic [4:0] w_addr,
                              logic [1:0] w_tag, logic [31:0] w_data, logic fl, logic r_en,
                              logic [4:0] r_addr, logic [1:0] e_atag, logic chk_d,
                              logic [31:0] e_data, logic [1:0] e_tag, logic e_dirty, logic [5:0] e_cnt);
    vec_t v;
    v.a_en = a_en; v.a_addr = a_addr; v.w_en = w_en; v.w_addr = w_addr; v.w_tag = w_tag;
    v.w_data = w_data; v.fl = fl; v.r_en = r_en; v.r_addr = r_addr; v.e_atag = e_atag;
    v.chk_d = chk_d; v.e_data = e_data; v.e_tag = e_tag; v.e_dirty = e_dirty; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    alloc_en = 0; alloc_addr = 0; wb_en = 0; wb_addr = 0; wb_tag = 0; wb_wdata = 0; flush = 0;
  endtask

  initial begin
    rst_n = 0; idle();
    rd_rf1_en = 1; rd_rf1_addr = 5; rd_rf2_en = 0; rd_rf2_addr = 0; rd_rf3_en = 0; rd_rf3_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dirty", 32'(rd_rf1_dirty), 0);
    chk("rst_tag", 32'(rd_rf1_tag), 0);
    chk("rst_cnt", 32'(dirty_cnt), 0);
`ifdef REG_FILE_SB_DATA_RST_EN
    chk("rst_data", rd_rf1_data, 0);
`endif
    @(negedge clk); rst_n = 1;

    //        a_en a_ad w_en w_ad wt  wdata         fl ren rad atag cd edata         etag ed cnt
    vecs.push_back(mk(1, 5,  0, 0,  0, 0,            0, 1, 5,  1, 0, 0,            1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 5,  1, 32'h1234,     0, 1, 5,  0, 1, 32'h1234,     1, 0, 0));
    vecs.push_back(mk(1, 7,  0, 0,  0, 0,            0, 1, 7,  1, 0, 0,            1, 1, 1));
    vecs.push_back(mk(1, 7,  0, 0,  0, 0,            0, 1, 7,  2, 0, 0,            2, 1, 1));
    vecs.push_back(mk(1, 7,  0, 0,  0, 0,            0, 1, 7,  3, 0, 0,            3, 1, 1));
    vecs.push_back(mk(1, 7,  0, 0,  0, 0,            0, 1, 7,  0, 0, 0,            0, 1, 1));
    vecs.push_back(mk(1, 7,  0, 0,  0, 0,            0, 1, 7,  1, 0, 0,            1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 7,  0, 32'hAAAA5555, 0, 1, 7,  0, 1, 32'hAAAA5555, 1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 7,  1, 32'h77,       0, 1, 7,  0, 1, 32'h77,       1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 9,  0, 32'h9,        0, 1, 9,  0, 1, 32'h9,        0, 0, 0));
    vecs.push_back(mk(1, 9,  1, 9,  0, 32'h99,       0, 1, 9,  1, 1, 32'h99,       1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 9,  1, 32'h999,      0, 1, 9,  0, 1, 32'h999,      1, 0, 0));
    vecs.push_back(mk(1, 1,  0, 0,  0, 0,            0, 1, 1,  1, 0, 0,            1, 1, 1));
    vecs.push_back(mk(1, 2,  0, 0,  0, 0,            0, 1, 2,  1, 0, 0,            1, 1, 2));
    vecs.push_back(mk(1, 3,  0, 0,  0, 0,            0, 1, 3,  1, 0, 0,            1, 1, 3));
    vecs.push_back(mk(1, 4,  0, 0,  0, 0,            1, 1, 4,  1, 0, 0,            1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 3,  0, 32'h33,       1, 1, 3,  0, 1, 32'h33,       1, 0, 0));
    vecs.push_back(mk(1, 0,  1, 0,  0, 32'hDEAD,     0, 1, 0,  0, 1, 0,            0, 0, 0));
    vecs.push_back(mk(1, 31, 0, 0,  0, 0,            0, 1, 31, 1, 0, 0,            1, 1, 1));
    vecs.push_back(mk(0, 0,  1, 31, 1, 32'hFFFFFFFF, 0, 1, 31, 0, 1, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mk(0, 0,  0, 0,  0, 0,            0, 0, 31, 0, 1, 0,            0, 0, 0));

    foreach (vecs[k]) begin
      alloc_en = vecs[k].a_en; alloc_addr = vecs[k].a_addr;
      wb_en = vecs[k].w_en; wb_addr = vecs[k].w_addr; wb_tag = vecs[k].w_tag; wb_wdata = vecs[k].w_data;
      flush = vecs[k].fl; rd_rf1_en = vecs[k].r_en; rd_rf1_addr = vecs[k].r_addr;
      #1;
      chk($sformatf("v%0d_alloc_tag", k), 32'(alloc_tag), 32'(vecs[k].e_atag));
      @(posedge clk); #1;
      if (vecs[k].chk_d) chk($sformatf("v%0d_data", k), rd_rf1_data, vecs[k].e_data);
      chk($sformatf("v%0d_tag", k), 32'(rd_rf1_tag), 32'(vecs[k].e_tag));
      chk($sformatf("v%0d_dirty", k), 32'(rd_rf1_dirty), 32'(vecs[k].e_dirty));
      chk($sformatf("v%0d_cnt", k), 32'(dirty_cnt), 32'(vecs[k].e_cnt));
      @(negedge clk);
    end

    // Reads see pre-edge state: no write-to-read bypass.
    idle();
    rd_rf2_en = 1; rd_rf2_addr = 5; rd_rf3_en = 1; rd_rf3_addr = 7;
    wb_en = 1; wb_addr = 5; wb_tag = 1; wb_wdata = 32'h5555;
    #1;
    chk("nobyp_pre_p2", rd_rf2_data, 32'h1234);
    chk("nobyp_pre_p3", rd_rf3_data, 32'h77);
    @(posedge clk); #1;
    chk("nobyp_post_p2", rd_rf2_data, 32'h5555);
    chk("nobyp_post_dirty", 32'(rd_rf2_dirty), 0);

    // Reset overrides alloc, wb and flush.
    @(negedge clk); idle();
    alloc_en = 1; alloc_addr = 6; rd_rf3_addr = 6;
    @(posedge clk); #1;
    chk("pre_rst_cnt", 32'(dirty_cnt), 1);
    chk("pre_rst_dirty6", 32'(rd_rf3_dirty), 1);
    @(negedge clk);
    rst_n = 0; flush = 1; wb_en = 1; wb_addr = 5; wb_tag = 0; wb_wdata = 32'hBEEF;
    @(posedge clk); #1;
    chk("rst_tag6", 32'(rd_rf3_tag), 0);
    chk("rst_dirty6", 32'(rd_rf3_dirty), 0);
    chk("rst_tag5", 32'(rd_rf2_tag), 0);
    chk("rst_cnt2", 32'(dirty_cnt), 0);
    chk("rst_alloc_tag6", 32'(alloc_tag), 1);
`ifdef REG_FILE_SB_DATA_RST_EN
    chk("rst_data5", rd_rf2_data, 0);
`else
    chk("rst_data5_hold", rd_rf2_data, 32'h5555);
`endif
    @(negedge clk); rst_n = 1; idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
